// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, protection width and the
// read-arbiter state encoding.
package axi_lite_pkg;

   localparam int unsigned PROT_W = 3;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [1:0] {
      IDLE,
      ADDR,
      DATA
   } state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: returns the first asserted request at or
// after ptr, wrapping modulo NUM_REQ.
module rr_pick #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic               found,
   output logic [IDX_W-1:0]   idx
);

   logic [IDX_W:0] sum;

   // Walk offsets from farthest to nearest so the nearest hit is written last.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      sum   = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         sum = {1'b0, ptr} + (IDX_W + 1)'(k);
         if (sum >= (IDX_W + 1)'(NUM_REQ)) begin
            sum = sum - (IDX_W + 1)'(NUM_REQ);
         end
         if (req[sum[IDX_W-1:0]]) begin
            found = 1'b1;
            idx   = sum[IDX_W-1:0];
         end
      end
   end

endmodule

// File: rtl/axi_lite_read_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite read channel (AR + R) between
// NUM_REQ requesters, one outstanding transaction at a time.
module axi_lite_read_arbiter
   import axi_lite_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32
) (
   input  logic                      ACLK,
   input  logic                      ARESET,
   input  logic [NUM_REQ-1:0]        S_ARVALID,
   output logic [NUM_REQ-1:0]        S_ARREADY,
   input  logic [NUM_REQ*ADDR_W-1:0] S_ARADDR,
   input  logic [NUM_REQ*PROT_W-1:0] S_ARPROT,
   output logic [NUM_REQ-1:0]        S_RVALID,
   input  logic [NUM_REQ-1:0]        S_RREADY,
   output logic [DATA_W-1:0]         S_RDATA,
   output logic [1:0]                S_RRESP,
   output logic                      M_ARVALID,
   input  logic                      M_ARREADY,
   output logic [ADDR_W-1:0]         M_ARADDR,
   output logic [PROT_W-1:0]         M_ARPROT,
   input  logic                      M_RVALID,
   output logic                      M_RREADY,
   input  logic [DATA_W-1:0]         M_RDATA,
   input  logic [1:0]                M_RRESP
);

   localparam int unsigned      IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [IDX_W-1:0] LAST  = IDX_W'(NUM_REQ - 1);

   state_e              state_q, state_d;
   logic [IDX_W-1:0]    ptr_q, ptr_d;
   logic [IDX_W-1:0]    grant_q, grant_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [PROT_W-1:0]   prot_q, prot_d;
   logic                pick_found;
   logic [IDX_W-1:0]    pick_idx;
   logic                r_ready;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_pick (
      .req   (S_ARVALID),
      .ptr   (ptr_q),
      .found (pick_found),
      .idx   (pick_idx)
   );

   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      grant_d   = grant_q;
      addr_d    = addr_q;
      prot_d    = prot_q;
      S_ARREADY = '0;
      S_RVALID  = '0;
      M_ARVALID = 1'b0;
      r_ready   = 1'b0;

      unique case (state_q)
         IDLE: begin
            // Accept is combinational, so it must be masked while reset is held.
            if (pick_found && !ARESET) begin
               S_ARREADY[pick_idx] = 1'b1;
               grant_d             = pick_idx;
               addr_d              = S_ARADDR[pick_idx*ADDR_W +: ADDR_W];
               prot_d              = S_ARPROT[pick_idx*PROT_W +: PROT_W];
               state_d             = ADDR;
            end
         end
         ADDR: begin
            M_ARVALID = 1'b1;
            if (M_ARREADY) begin
               state_d = DATA;
            end
         end
         DATA: begin
            r_ready           = S_RREADY[grant_q];
            S_RVALID[grant_q] = M_RVALID;
            if (M_RVALID && r_ready) begin
               ptr_d   = (grant_q == LAST) ? '0 : grant_q + 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         grant_q <= '0;
         addr_q  <= '0;
         prot_q  <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         grant_q <= grant_d;
         addr_q  <= addr_d;
         prot_q  <= prot_d;
      end
   end

   assign M_RREADY = r_ready;
   assign M_ARADDR = addr_q;
   assign M_ARPROT = prot_q;
   assign S_RDATA  = M_RDATA;
   assign S_RRESP  = M_RRESP;

endmodule

// File: tb/tb_axi_lite_read_arbiter.sv
// Self-checking bench for axi_lite_read_arbiter: vector table, directed
// multi-cycle sequences and randomized traffic against a transaction model.
module tb_axi_lite_read_arbiter;
   import axi_lite_pkg::*;

   localparam int N = 4;

   logic          ACLK = 1'b0;
   logic          ARESET;
   logic [N-1:0]  S_ARVALID, S_ARREADY, S_RVALID, S_RREADY;
   logic [N*32-1:0] S_ARADDR;
   logic [N*3-1:0]  S_ARPROT;
   logic [31:0]   S_RDATA, M_ARADDR, M_RDATA;
   logic [1:0]    S_RRESP, M_RRESP;
   logic          M_ARVALID, M_ARREADY, M_RVALID, M_RREADY;
   logic [2:0]    M_ARPROT;

   logic [31:0]   addr_a [N];
   logic [2:0]    prot_a [N];

   assign S_ARADDR = {addr_a[3], addr_a[2], addr_a[1], addr_a[0]};
   assign S_ARPROT = {prot_a[3], prot_a[2], prot_a[1], prot_a[0]};

   always #5 ACLK = ~ACLK;

   axi_lite_read_arbiter #(
      .NUM_REQ (N),
      .ADDR_W  (32),
      .DATA_W  (32)
   ) dut (
      .ACLK      (ACLK),
      .ARESET    (ARESET),
      .S_ARVALID (S_ARVALID),
      .S_ARREADY (S_ARREADY),
      .S_ARADDR  (S_ARADDR),
      .S_ARPROT  (S_ARPROT),
      .S_RVALID  (S_RVALID),
      .S_RREADY  (S_RREADY),
      .S_RDATA   (S_RDATA),
      .S_RRESP   (S_RRESP),
      .M_ARVALID (M_ARVALID),
      .M_ARREADY (M_ARREADY),
      .M_ARADDR  (M_ARADDR),
      .M_ARPROT  (M_ARPROT),
      .M_RVALID  (M_RVALID),
      .M_RREADY  (M_RREADY),
      .M_RDATA   (M_RDATA),
      .M_RRESP   (M_RRESP)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge ACLK);
      #1;
   endtask

   // Leaves the bench at posedge+1 with reset released and inputs idle.
   task automatic do_reset(input bit check);
      ARESET    = 1'b1;
      S_ARVALID = '0;
      S_RREADY  = '0;
      M_ARREADY = 1'b0;
      M_RVALID  = 1'b0;
      M_RDATA   = '0;
      M_RRESP   = '0;
      @(negedge ACLK);
      if (check) begin
         chk("rst_arready", 64'(S_ARREADY), 64'h0);
         chk("rst_rvalid", 64'(S_RVALID), 64'h0);
         chk("rst_marvalid", 64'(M_ARVALID), 64'h0);
         chk("rst_maraddr", 64'(M_ARADDR), 64'h0);
         chk("rst_marprot", 64'(M_ARPROT), 64'h0);
         chk("rst_mrready", 64'(M_RREADY), 64'h0);
      end
      @(posedge ACLK);
      #1 ARESET = 1'b0;
   endtask

   typedef struct {
      logic [3:0]  arv;
      logic        m_arr;
      logic        m_rv;
      logic [3:0]  rr;
      logic [31:0] rdata;
      logic [1:0]  rresp;
      logic [3:0]  e_arr;
      logic        e_mav;
      logic [31:0] e_maddr;
      logic        e_mrr;
      logic [3:0]  e_srv;
   } vec_t;

   vec_t vecs [13];

   // Reference model state for the randomized phase.
   int          m_owner;
   bit          m_addr_done;
   int          m_ptr;
   logic [31:0] m_addr;
   logic [2:0]  m_prot;

   initial begin
      for (int i = 0; i < N; i++) begin
         addr_a[i] = 32'h0000_1000 + ((32'(i) ^ 32'd2) << 8);
         prot_a[i] = 3'(i);
      end

      // Single request to 2, then wrap behaviour around requester 3.
      vecs[0]  = '{4'b0100, 1'b1, 1'b0, 4'hF, 32'h0,         2'b00, 4'b0100, 1'b0, 32'h0,    1'b0, 4'b0000};
      vecs[1]  = '{4'b0000, 1'b1, 1'b1, 4'hF, 32'hDEAD_BEEF, 2'b00, 4'b0000, 1'b1, 32'h1000, 1'b0, 4'b0000};
      vecs[2]  = '{4'b0000, 1'b1, 1'b1, 4'hF, 32'hDEAD_BEEF, 2'b00, 4'b0000, 1'b0, 32'h1000, 1'b1, 4'b0100};
      vecs[3]  = '{4'b1001, 1'b1, 1'b0, 4'hF, 32'h0,         2'b00, 4'b1000, 1'b0, 32'h1000, 1'b0, 4'b0000};
      vecs[4]  = '{4'b0000, 1'b0, 1'b0, 4'hF, 32'h0,         2'b00, 4'b0000, 1'b1, 32'h1100, 1'b0, 4'b0000};
      vecs[5]  = '{4'b0000, 1'b1, 1'b0, 4'hF, 32'h0,         2'b00, 4'b0000, 1'b1, 32'h1100, 1'b0, 4'b0000};
      vecs[6]  = '{4'b0000, 1'b1, 1'b1, 4'h7, 32'hCAFE_0001, 2'b00, 4'b0000, 1'b0, 32'h1100, 1'b0, 4'b1000};
      vecs[7]  = '{4'b0000, 1'b1, 1'b1, 4'hF, 32'hCAFE_0001, 2'b00, 4'b0000, 1'b0, 32'h1100, 1'b1, 4'b1000};
      vecs[8]  = '{4'b1001, 1'b1, 1'b0, 4'hF, 32'h0,         2'b00, 4'b0001, 1'b0, 32'h1100, 1'b0, 4'b0000};
      vecs[9]  = '{4'b1001, 1'b1, 1'b0, 4'hF, 32'h0,         2'b00, 4'b0000, 1'b1, 32'h1200, 1'b0, 4'b0000};
      vecs[10] = '{4'b1001, 1'b1, 1'b0, 4'hF, 32'h0,         2'b00, 4'b0000, 1'b0, 32'h1200, 1'b1, 4'b0000};
      vecs[11] = '{4'b1001, 1'b1, 1'b1, 4'hF, 32'h1234_5678, 2'b10, 4'b0000, 1'b0, 32'h1200, 1'b1, 4'b0001};
      vecs[12] = '{4'b1001, 1'b1, 1'b0, 4'hF, 32'h0,         2'b00, 4'b1000, 1'b0, 32'h1200, 1'b0, 4'b0000};

      do_reset(1'b1);
      for (int v = 0; v < 13; v++) begin
         S_ARVALID = vecs[v].arv;
         M_ARREADY = vecs[v].m_arr;
         M_RVALID  = vecs[v].m_rv;
         S_RREADY  = vecs[v].rr;
         M_RDATA   = vecs[v].rdata;
         M_RRESP   = vecs[v].rresp;
         @(negedge ACLK);
         chk($sformatf("vec%0d_arready", v), 64'(S_ARREADY), 64'(vecs[v].e_arr));
         chk($sformatf("vec%0d_marvalid", v), 64'(M_ARVALID), 64'(vecs[v].e_mav));
         chk($sformatf("vec%0d_maraddr", v), 64'(M_ARADDR), 64'(vecs[v].e_maddr));
         chk($sformatf("vec%0d_mrready", v), 64'(M_RREADY), 64'(vecs[v].e_mrr));
         chk($sformatf("vec%0d_rvalid", v), 64'(S_RVALID), 64'(vecs[v].e_srv));
         chk($sformatf("vec%0d_rdata", v), 64'(S_RDATA), 64'(vecs[v].rdata));
         chk($sformatf("vec%0d_rresp", v), 64'(S_RRESP), 64'(vecs[v].rresp));
         step();
      end

      // All four requesting continuously: grants 0,1,2,3,0 every 3 cycles.
      do_reset(1'b0);
      S_ARVALID = 4'hF;
      M_ARREADY = 1'b1;
      M_RVALID  = 1'b1;
      S_RREADY  = 4'hF;
      for (int t = 0; t < 5; t++) begin
         @(negedge ACLK);
         chk($sformatf("rr%0d_arready", t), 64'(S_ARREADY), 64'(4'b0001 << (t % 4)));
         step();
         @(negedge ACLK);
         chk($sformatf("rr%0d_marvalid", t), 64'(M_ARVALID), 64'h1);
         chk($sformatf("rr%0d_maraddr", t), 64'(M_ARADDR), 64'(addr_a[t % 4]));
         chk($sformatf("rr%0d_marprot", t), 64'(M_ARPROT), 64'(prot_a[t % 4]));
         step();
         @(negedge ACLK);
         chk($sformatf("rr%0d_rvalid", t), 64'(S_RVALID), 64'(4'b0001 << (t % 4)));
         step();
      end

      // Address stall, then data stall on S_RREADY, then async reset in DATA.
      do_reset(1'b0);
      S_ARVALID = 4'b0010;
      M_ARREADY = 1'b0;
      S_RREADY  = 4'h0;
      step();
      S_ARVALID = 4'hF;
      for (int c = 0; c < 5; c++) begin
         @(negedge ACLK);
         chk("stall_marvalid", 64'(M_ARVALID), 64'h1);
         chk("stall_maraddr", 64'(M_ARADDR), 64'(addr_a[1]));
         chk("stall_arready", 64'(S_ARREADY), 64'h0);
         step();
      end
      M_ARREADY = 1'b1;
      step();
      M_RVALID = 1'b1;
      M_RDATA  = 32'hA5A5_0F0F;
      for (int c = 0; c < 3; c++) begin
         @(negedge ACLK);
         chk("rhold_mrready", 64'(M_RREADY), 64'h0);
         chk("rhold_rvalid", 64'(S_RVALID), 64'(4'b0010));
         chk("rhold_rdata", 64'(S_RDATA), 64'hA5A5_0F0F);
         step();
      end
      S_RREADY = 4'hF;
      @(negedge ACLK);
      chk("rhold_done_mrready", 64'(M_RREADY), 64'h1);
      step();
      M_RVALID = 1'b0;
      @(negedge ACLK);
      chk("after_hold_arready", 64'(S_ARREADY), 64'(4'b0100));
      step();
      step();
      @(negedge ACLK);
      chk("pre_rst_mrready", 64'(M_RREADY), 64'h1);
      #2 ARESET = 1'b1;
      #1;
      chk("arst_arready", 64'(S_ARREADY), 64'h0);
      chk("arst_marvalid", 64'(M_ARVALID), 64'h0);
      chk("arst_mrready", 64'(M_RREADY), 64'h0);
      chk("arst_rvalid", 64'(S_RVALID), 64'h0);
      chk("arst_maraddr", 64'(M_ARADDR), 64'h0);
      chk("arst_marprot", 64'(M_ARPROT), 64'h0);
      @(posedge ACLK);
      #1 ARESET = 1'b0;
      S_ARVALID = 4'b0110;
      @(negedge ACLK);
      chk("post_rst_arready", 64'(S_ARREADY), 64'(4'b0010));
      step();
      S_ARVALID = 4'b0000;
      step();
      M_RVALID = 1'b1;
      M_RRESP  = RESP_SLVERR;
      @(negedge ACLK);
      chk("slverr_rresp", 64'(S_RRESP), 64'(RESP_SLVERR));
      chk("slverr_rvalid", 64'(S_RVALID), 64'(4'b0010));
      step();

      // Randomized traffic against a transaction-level model.
      do_reset(1'b0);
      m_owner     = -1;
      m_addr_done = 1'b0;
      m_ptr       = 0;
      m_addr      = '0;
      m_prot      = '0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         int          winner;
         logic [3:0]  e_arr, e_srv;
         logic        e_mav, e_mrr;
         S_ARVALID = 4'($urandom_range(0, 15));
         M_ARREADY = 1'($urandom_range(0, 1));
         M_RVALID  = 1'($urandom_range(0, 1));
         S_RREADY  = 4'($urandom_range(0, 15));
         M_RDATA   = $urandom;
         M_RRESP   = 2'($urandom_range(0, 3));
         for (int i = 0; i < N; i++) begin
            addr_a[i] = $urandom;
            prot_a[i] = 3'($urandom_range(0, 7));
         end
         winner = -1;
         e_arr  = '0;
         e_srv  = '0;
         e_mav  = 1'b0;
         e_mrr  = 1'b0;
         if (m_owner < 0) begin
            for (int k = N - 1; k >= 0; k--) begin
               if (S_ARVALID[(m_ptr + k) % N]) winner = (m_ptr + k) % N;
            end
            if (winner >= 0) e_arr[winner] = 1'b1;
         end else if (!m_addr_done) begin
            e_mav = 1'b1;
         end else begin
            e_mrr = S_RREADY[m_owner];
            if (M_RVALID) e_srv[m_owner] = 1'b1;
         end
         @(negedge ACLK);
         chk("rnd_arready", 64'(S_ARREADY), 64'(e_arr));
         chk("rnd_marvalid", 64'(M_ARVALID), 64'(e_mav));
         chk("rnd_maraddr", 64'(M_ARADDR), 64'(m_addr));
         chk("rnd_marprot", 64'(M_ARPROT), 64'(m_prot));
         chk("rnd_mrready", 64'(M_RREADY), 64'(e_mrr));
         chk("rnd_rvalid", 64'(S_RVALID), 64'(e_srv));
         chk("rnd_rdata", 64'(S_RDATA), 64'(M_RDATA));
         chk("rnd_rresp", 64'(S_RRESP), 64'(M_RRESP));
         if (m_owner < 0) begin
            if (winner >= 0) begin
               m_owner     = winner;
               m_addr_done = 1'b0;
               m_addr      = addr_a[winner];
               m_prot      = prot_a[winner];
            end
         end else if (!m_addr_done) begin
            if (M_ARREADY) m_addr_done = 1'b1;
         end else if (M_RVALID && S_RREADY[m_owner]) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
         end
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/axi_lite_read_arbiter.md
# axi_lite_read_arbiter

Round-robin arbiter sharing one AXI4-Lite read channel (AR + R) between NUM_REQ requesters. It sits between several read masters and the single master-side read address/data interface that feeds the read address channel block. It allows one outstanding transaction at a time. It registers the winning address and protection bits, drives the shared AR channel, and routes the R response back only to the granted requester.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_W, 32, address width
- DATA_W, 32, read data width

- ACLK  in  1  clock, all logic on rising edge
- ARESET  in  1  asynchronous, active-high reset
- S_ARVALID  in  NUM_REQ  per-requester address valid
- S_ARREADY  out  NUM_REQ  per-requester address accept (one-hot or zero)
- S_ARADDR  in  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
- S_ARPROT  in  NUM_REQ*3  packed protection bits
- S_RVALID  out  NUM_REQ  per-requester read valid (one-hot or zero)
- S_RREADY  in  NUM_REQ  per-requester read ready
- S_RDATA  out  DATA_W  broadcast read data, qualified by S_RVALID
- S_RRESP  out  2  broadcast response, qualified by S_RVALID
- M_ARVALID  out  1  shared address valid
- M_ARREADY  in  1  shared address ready
- M_ARADDR  out  ADDR_W  latched winning address
- M_ARPROT  out  3  latched winning protection
- M_RVALID  in  1  shared read valid
- M_RREADY  out  1  shared read ready
- M_RDATA  in  DATA_W  shared read data
- M_RRESP  in  2  shared read response

## Operation
- States: IDLE, ADDR, DATA.
- IDLE: the winner is the first i with S_ARVALID[i]=1, searching from ptr upward and wrapping modulo NUM_REQ.
  - S_ARREADY[winner]=1 combinationally in the same cycle.
  - On that edge: latch S_ARADDR/S_ARPROT of the winner, grant<=winner, go to ADDR.
  - With no valid requester, stay in IDLE with all S_ARREADY=0.
- ADDR: M_ARVALID=1, M_ARADDR/M_ARPROT held constant. On M_ARVALID&&M_ARREADY, go to DATA. M_ARVALID is never withdrawn before the handshake.
- DATA: M_RREADY=S_RREADY[grant], S_RVALID[grant]=M_RVALID, all other S_RVALID=0. S_RDATA=M_RDATA and S_RRESP=M_RRESP pass through combinationally.
  - On M_RVALID&&M_RREADY: ptr<=(grant+1) mod NUM_REQ, go to IDLE.
- Fairness: a requester that just completed has lowest priority next arbitration. Any continuously asserting requester is served within NUM_REQ transactions.
- S_ARREADY is 0 outside IDLE. Requests arriving during ADDR/DATA wait.
- SLVERR/DECERR responses are forwarded unchanged. They do not affect arbitration.

## Timing
- Reset (async assert, state updates on next edge after deassert):
  - state=IDLE, ptr=0, grant=0
  - M_ARVALID=0, M_ARADDR=0, M_ARPROT=0, M_RREADY=0
  - S_ARREADY=0, S_RVALID=0
- Latency: requester AR handshake at edge N. M_ARVALID=1 from cycle N+1. Minimum R handshake at N+2 (M_ARREADY already high in N+1, M_RVALID high in N+2).
- Minimum transaction period is 3 cycles (IDLE, ADDR, DATA). Back-to-back grants need no extra idle cycle.
- Simultaneous requests: resolved only by ptr order. No requester is ever granted twice without its AR handshake.
- Reset mid-ADDR or mid-DATA: the transaction is abandoned and all outputs return to reset values. Downstream reset is the system's responsibility.
- ptr wrap: grant=NUM_REQ-1 leads to ptr=0.

## Structure
- Shared package axi_lite_pkg holds:
  - RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11
  - the state enum {IDLE, ADDR, DATA}
  - the 3-bit PROT width constant
- One sub-module, rr_pick: combinational round-robin picker.
  - Inputs: req[NUM_REQ], ptr.
  - Outputs: found, idx (clog2 width).
  - Instantiated once.

## Test plan
- Single request: S_ARVALID=4'b0100, S_ARADDR[2]=32'h0000_1000, M_ARREADY=1, M_RVALID one cycle later with RDATA=32'hDEAD_BEEF → S_ARREADY=4'b0100 for one cycle; M_ARADDR=32'h0000_1000; S_RVALID=4'b0100 with DEAD_BEEF; ptr=3.
- All four requesting continuously from reset → grant order 0,1,2,3,0, one transaction per 3 cycles.
- M_ARREADY held low 5 cycles → M_ARVALID stays 1 and M_ARADDR stable throughout; no S_ARREADY asserted.
- DATA with S_RREADY[grant]=0 for 3 cycles while M_RVALID=1 → M_RREADY=0, state stays DATA, S_RDATA stable; completes when S_RREADY rises.
- Wrap: grant=3 completes with S_ARVALID=4'b1001 → next grant is 0, not 3.
- ARESET pulsed during DATA → all outputs at reset values immediately; next arbitration starts with ptr=0; M_RRESP=SLVERR on a following read is forwarded unchanged.
